// File: rtl/la_disp_pkg.sv
// Shared display constants for the logic-analyzer wave renderer.
package la_disp_pkg;

  // Input-to-output pipeline depth, shared by sync and pixel paths
  localparam int unsigned LAT        = 3;
  localparam int unsigned CH_TABLE_N = 8;
  localparam int unsigned CH_IDX_W   = 3;
  localparam int unsigned COLOR_W    = 24;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam logic [COLOR_W-1:0] GRID_COLOR = 24'h404040;
  localparam logic [COLOR_W-1:0] TRIG_COLOR = 24'hFF0000;
  localparam logic [COLOR_W-1:0] BG_COLOR   = 24'h000000;

  // Channel trace colors, entry 0 in the least-significant slot
  localparam logic [CH_TABLE_N-1:0][COLOR_W-1:0] CH_COLOR = {
    24'h80FF80,  // ch7
    24'hFFFFFF,  // ch6
    24'h8080FF,  // ch5
    24'hFF8000,  // ch4
    24'hFF00FF,  // ch3
    24'h00FFFF,  // ch2
    24'hFFFF00,  // ch1
    24'h00FF00   // ch0
  };

  // Trace color lookup for one channel
  function automatic rgb_t ch_color(input logic [CH_IDX_W-1:0] ch);
    return rgb_t'(CH_COLOR[ch]);
  endfunction

endpackage

// File: rtl/la_sync_delay.sv
// N-stage delay line for vs/hs/de so sync stays aligned with rendered RGB.
module la_sync_delay #(
  parameter int unsigned N = 3
) (
  input  logic pix_clk,
  input  logic rstn,
  input  logic vs_in,
  input  logic hs_in,
  input  logic de_in,
  output logic vs_out,
  output logic hs_out,
  output logic de_out
);

  logic [N-1:0][2:0] sr_q;
  logic [N-1:0][2:0] sr_d;

  // Shift the {vs,hs,de} triple one stage per pixel clock
  always_comb begin
    sr_d    = sr_q;
    sr_d[0] = {vs_in, hs_in, de_in};
    for (int i = 1; i < int'(N); i++) begin
      sr_d[i] = sr_q[i-1];
    end
  end

  // Delay-line registers
  always_ff @(posedge pix_clk or negedge rstn) begin
    if (!rstn) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign {vs_out, hs_out, de_out} = sr_q[N-1];

endmodule

// File: rtl/la_wave_render.sv
// Logic-analyzer trace renderer: fetches samples per pixel and draws
// one digital trace per channel with grid, transitions and trigger marker.
module la_wave_render
  import la_disp_pkg::*;
#(
  parameter int unsigned        X_BITS     = 12,
  parameter int unsigned        Y_BITS     = 12,
  parameter int unsigned        ADDR_W     = 12,
  parameter int unsigned        CH_NUM     = CH_TABLE_N,
  parameter int unsigned        LANE_SHIFT = 7,
  parameter logic [Y_BITS-1:0]  Y_OFF      = Y_BITS'(16),
  parameter int unsigned        HI_ROW     = 16,
  parameter int unsigned        LO_ROW     = 112,
  parameter int unsigned        GRID_SHIFT = 6
) (
  input  logic              pix_clk,
  input  logic              rstn,
  input  logic              vs_in,
  input  logic              hs_in,
  input  logic              de_in,
  input  logic [X_BITS-1:0] act_x,
  input  logic [Y_BITS-1:0] act_y,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] trig_addr,
  input  logic [2:0]        zoom_shift,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [CH_NUM-1:0] ram_data,
  output logic              vs_out,
  output logic              hs_out,
  output logic              de_out,
  output logic [7:0]        r_out,
  output logic [7:0]        g_out,
  output logic [7:0]        b_out
);

  localparam int unsigned ZOOM_W = 3;
  localparam int unsigned SUB_W  = 7;
  localparam int unsigned LANE_W = $clog2(CH_NUM);

  // Frame registers
  logic              vs_q, vs_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] trig_q, trig_d;
  logic [ZOOM_W-1:0] zoom_q, zoom_d;

  // Stage 1: address issue
  logic              ram_rd_en_q, ram_rd_en_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              de1_q, de1_d;
  logic              hit1_q, hit1_d;
  logic [SUB_W-1:0]  sub1_q, sub1_d;
  logic [X_BITS-1:0] x1_q, x1_d;
  logic [Y_BITS-1:0] y1_q, y1_d;

  // Stage 2: waiting on RAM read
  logic              de2_q, de2_d;
  logic              hit2_q, hit2_d;
  logic [SUB_W-1:0]  sub2_q, sub2_d;
  logic [X_BITS-1:0] x2_q, x2_d;
  logic [Y_BITS-1:0] y2_q, y2_d;

  // Stage 3: color decision
  logic [CH_NUM-1:0] prev_q, prev_d;
  rgb_t              rgb_q, rgb_d;

  // Stage 1 helpers
  logic [X_BITS-1:0] sub_mask;
  logic [ADDR_W-1:0] samp_idx;

  // Stage 3 helpers
  logic              first_px;
  logic              samp_edge;
  logic [CH_NUM-1:0] tflag;
  logic [Y_BITS-1:0] ry;
  logic [Y_BITS-1:0] lane_full;
  logic [LANE_W-1:0] lane_idx;
  logic [LANE_SHIFT-1:0] row;
  logic              lane_ok;
  logic              trace;
  logic              grid;

  // Latch view parameters on vs rising; current pixel still sees old values
  always_comb begin
    vs_d   = vs_in;
    base_d = base_q;
    trig_d = trig_q;
    zoom_d = zoom_q;
    if (vs_in && !vs_q) begin
      base_d = base_addr;
      trig_d = trig_addr;
      zoom_d = zoom_shift;
    end
  end

  // Stage 1: sample index, sub-sample phase and trigger hit
  always_comb begin
    sub_mask    = (X_BITS'(1) << zoom_q) - X_BITS'(1);
    samp_idx    = ADDR_W'(base_q + ADDR_W'(act_x >> zoom_q));
    ram_addr_d  = samp_idx;
    ram_rd_en_d = de_in;
    de1_d       = de_in;
    sub1_d      = SUB_W'(act_x & sub_mask);
    hit1_d      = (samp_idx == trig_q) && (sub1_d == '0);
    x1_d        = act_x;
    y1_d        = act_y;
  end

  // Stage 2: align pixel fields with the RAM read latency
  always_comb begin
    de2_d  = de1_q;
    hit2_d = hit1_q;
    sub2_d = sub1_q;
    x2_d   = x1_q;
    y2_d   = y1_q;
  end

  // Stage 3: transition tracking, lane geometry and pixel priority
  always_comb begin
    first_px  = (x2_q == '0);
    samp_edge = (sub2_q == '0);
    tflag     = '0;
    prev_d    = prev_q;
    if (de2_q && samp_edge && !first_px) begin
      tflag = ram_data ^ prev_q;
    end
    if (de2_q && (first_px || samp_edge)) begin
      prev_d = ram_data;
    end

    ry        = y2_q - Y_OFF;
    lane_full = ry >> LANE_SHIFT;
    lane_idx  = LANE_W'(lane_full);
    row       = ry[LANE_SHIFT-1:0];
    lane_ok   = (y2_q >= Y_OFF) && (lane_full < Y_BITS'(CH_NUM));
    trace     = lane_ok &&
                (((row == LANE_SHIFT'(HI_ROW)) && ram_data[lane_idx]) ||
                 ((row == LANE_SHIFT'(LO_ROW)) && !ram_data[lane_idx]) ||
                 ((row >= LANE_SHIFT'(HI_ROW)) && (row <= LANE_SHIFT'(LO_ROW)) &&
                  tflag[lane_idx]));
    grid      = (x2_q[GRID_SHIFT-1:0] == '0);

    rgb_d = rgb_t'(BG_COLOR);
    if (!de2_q) begin
      rgb_d = rgb_t'(BG_COLOR);
    end else if (hit2_q) begin
      rgb_d = rgb_t'(TRIG_COLOR);
    end else if (trace) begin
      rgb_d = ch_color(CH_IDX_W'(lane_idx));
    end else if (grid) begin
      rgb_d = rgb_t'(GRID_COLOR);
    end
  end

  // Pipeline and frame registers
  always_ff @(posedge pix_clk or negedge rstn) begin
    if (!rstn) begin
      vs_q        <= 1'b0;
      base_q      <= '0;
      trig_q      <= '0;
      zoom_q      <= '0;
      ram_rd_en_q <= 1'b0;
      ram_addr_q  <= '0;
      de1_q       <= 1'b0;
      hit1_q      <= 1'b0;
      sub1_q      <= '0;
      x1_q        <= '0;
      y1_q        <= '0;
      de2_q       <= 1'b0;
      hit2_q      <= 1'b0;
      sub2_q      <= '0;
      x2_q        <= '0;
      y2_q        <= '0;
      prev_q      <= '0;
      rgb_q       <= '0;
    end else begin
      vs_q        <= vs_d;
      base_q      <= base_d;
      trig_q      <= trig_d;
      zoom_q      <= zoom_d;
      ram_rd_en_q <= ram_rd_en_d;
      ram_addr_q  <= ram_addr_d;
      de1_q       <= de1_d;
      hit1_q      <= hit1_d;
      sub1_q      <= sub1_d;
      x1_q        <= x1_d;
      y1_q        <= y1_d;
      de2_q       <= de2_d;
      hit2_q      <= hit2_d;
      sub2_q      <= sub2_d;
      x2_q        <= x2_d;
      y2_q        <= y2_d;
      prev_q      <= prev_d;
      rgb_q       <= rgb_d;
    end
  end

  // Sync path delayed to match the pixel pipeline
  la_sync_delay #(
    .N (LAT)
  ) u_sync_delay (
    .pix_clk (pix_clk),
    .rstn    (rstn),
    .vs_in   (vs_in),
    .hs_in   (hs_in),
    .de_in   (de_in),
    .vs_out  (vs_out),
    .hs_out  (hs_out),
    .de_out  (de_out)
  );

  assign ram_rd_en = ram_rd_en_q;
  assign ram_addr  = ram_addr_q;
  assign r_out     = rgb_q.r;
  assign g_out     = rgb_q.g;
  assign b_out     = rgb_q.b;

endmodule

// File: tb/tb_la_wave_render.sv
// Bench for la_wave_render: behavioural pixel model feeding a scoreboard,
// table-driven address vectors and hand sequences for reset/frame corners.
module tb_la_wave_render;

  logic        pix_clk = 1'b0;
  logic        rstn = 1'b0;
  logic        vs_in = 1'b0, hs_in = 1'b0, de_in = 1'b0;
  logic [11:0] act_x = '0, act_y = '0;
  logic [11:0] base_addr = '0, trig_addr = '0;
  logic [2:0]  zoom_shift = '0;
  logic        ram_rd_en;
  logic [11:0] ram_addr;
  logic [7:0]  ram_data = '0;
  logic        vs_out, hs_out, de_out;
  logic [7:0]  r_out, g_out, b_out;

  la_wave_render dut (
    .pix_clk    (pix_clk),
    .rstn       (rstn),
    .vs_in      (vs_in),
    .hs_in      (hs_in),
    .de_in      (de_in),
    .act_x      (act_x),
    .act_y      (act_y),
    .base_addr  (base_addr),
    .trig_addr  (trig_addr),
    .zoom_shift (zoom_shift),
    .ram_rd_en  (ram_rd_en),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .vs_out     (vs_out),
    .hs_out     (hs_out),
    .de_out     (de_out),
    .r_out      (r_out),
    .g_out      (g_out),
    .b_out      (b_out)
  );

  always #5 pix_clk = ~pix_clk;

  // Synchronous sample RAM: data valid the cycle after the address is sampled
  logic [7:0] mem [0:4095];
  always @(posedge pix_clk) begin
    if (ram_rd_en) ram_data <= mem[ram_addr];
  end

  typedef struct packed {
    logic        vs;
    logic        hs;
    logic        de;
    logic [23:0] rgb;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // Reference state
  logic        m_vs = 1'b0;
  logic [11:0] m_base = '0, m_trig = '0;
  logic [2:0]  m_zoom = '0;
  logic [7:0]  m_prev = '0;
  logic        pend_de = 1'b0;
  logic [11:0] pend_addr = '0;
  int          red_cnt = 0, gray_cnt = 0, green_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] tb_ch_color(input int ch);
    case (ch)
      0: return 24'h00FF00;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'hFF00FF;
      4: return 24'hFF8000;
      5: return 24'h8080FF;
      6: return 24'hFFFFFF;
      default: return 24'h80FF80;
    endcase
  endfunction

  // Expected output for one input pixel; updates reference state
  task automatic model(input logic vs, input logic hs, input logic de,
                       input logic [11:0] x, input logic [11:0] y,
                       output exp_t e, output logic [11:0] idx);
    logic [11:0] ry, lane;
    logic [6:0]  row, sub;
    logic [7:0]  d, tf;
    logic [2:0]  li;
    e = '0;
    e.vs = vs; e.hs = hs; e.de = de;
    idx = 12'(m_base + (x >> m_zoom));
    sub = 7'(x % (12'd1 << m_zoom));
    if (de) begin
      d  = mem[idx];
      tf = ((sub == 7'd0) && (x != 12'd0)) ? (d ^ m_prev) : 8'h00;
      if ((x == 12'd0) || (sub == 7'd0)) m_prev = d;
      ry   = y - 12'd16;
      lane = ry / 12'd128;
      row  = 7'(ry % 12'd128);
      li   = lane[2:0];
      if ((idx == m_trig) && (sub == 7'd0))
        e.rgb = 24'hFF0000;
      else if ((y >= 12'd16) && (lane < 12'd8) &&
               (((row == 7'd16) && d[li]) || ((row == 7'd112) && !d[li]) ||
                ((row >= 7'd16) && (row <= 7'd112) && tf[li])))
        e.rgb = tb_ch_color(int'(li));
      else if (x[5:0] == 6'd0)
        e.rgb = 24'h404040;
    end
    if (vs && !m_vs) begin
      m_base = base_addr; m_trig = trig_addr; m_zoom = zoom_shift;
    end
    m_vs = vs;
  endtask

  // One pixel clock: check what emerged, then drive next input
  task automatic step(input logic vs, input logic hs, input logic de,
                      input logic [11:0] x, input logic [11:0] y);
    exp_t e, got;
    logic [11:0] idx;
    @(posedge pix_clk);
    #1;
    got = {vs_out, hs_out, de_out, r_out, g_out, b_out};
    if (sbq.size() == 3) begin
      e = sbq.pop_front();
      chk("pixel", 32'(got), 32'(e));
    end
    chk("rd_en", 32'(ram_rd_en), 32'(pend_de));
    if (pend_de) chk("addr", 32'(ram_addr), 32'(pend_addr));
    if (got.de && got.rgb == 24'hFF0000) red_cnt++;
    if (got.de && got.rgb == 24'h404040) gray_cnt++;
    if (got.de && got.rgb == 24'h00FF00) green_cnt++;
    vs_in = vs; hs_in = hs; de_in = de; act_x = x; act_y = y;
    model(vs, hs, de, x, y, e, idx);
    sbq.push_back(e);
    pend_de = de;
    pend_addr = idx;
  endtask

  task automatic release_reset();
    vs_in = 0; hs_in = 0; de_in = 0; act_x = '0; act_y = '0;
    sbq.delete();
    m_vs = 0; m_base = '0; m_trig = '0; m_zoom = '0; m_prev = '0;
    pend_de = 0;
    #2 rstn = 1'b1;
    for (int i = 0; i < 3; i++) sbq.push_back('0);
  endtask

  task automatic set_frame(input logic [11:0] b, input logic [11:0] t, input logic [2:0] z);
    base_addr = b; trig_addr = t; zoom_shift = z;
    step(1, 0, 0, '0, '0);
    step(1, 0, 0, '0, '0);
    step(0, 0, 0, '0, '0);
    step(0, 0, 0, '0, '0);
  endtask

  task automatic line(input logic [11:0] y, input int nx);
    red_cnt = 0; gray_cnt = 0; green_cnt = 0;
    for (int x = 0; x < nx; x++) step(0, 0, 1, 12'(x), y);
    for (int i = 0; i < 3; i++) step(0, 1, 0, '0, '0);
    step(0, 0, 0, '0, '0);
    step(0, 0, 0, '0, '0);
  endtask

  typedef struct {
    logic [11:0] base;
    logic [2:0]  zoom;
    logic [11:0] x;
    logic [11:0] exp_addr;
  } avec_t;

  avec_t av[6];
  logic [11:0] wrap_seq[4];

  initial begin
    av[0] = '{12'h100, 3'd0, 12'd5,    12'h105};
    av[1] = '{12'h100, 3'd3, 12'd17,   12'h102};
    av[2] = '{12'hFFE, 3'd0, 12'd1,    12'hFFF};
    av[3] = '{12'hFFE, 3'd0, 12'd2,    12'h000};
    av[4] = '{12'h010, 3'd7, 12'd300,  12'h012};
    av[5] = '{12'h000, 3'd2, 12'd4095, 12'h3FF};
    wrap_seq[0] = 12'hFFE; wrap_seq[1] = 12'hFFF;
    wrap_seq[2] = 12'h000; wrap_seq[3] = 12'h001;
    for (int a = 0; a < 4096; a++) mem[a] = 8'h00;

    // Reset held with toggling syncs
    for (int i = 0; i < 6; i++) begin
      vs_in = i[0]; hs_in = ~i[0]; de_in = i[1]; act_x = 12'(i);
      @(negedge pix_clk);
      chk("reset_outs", 32'({vs_out, hs_out, de_out, r_out, g_out, b_out, ram_rd_en}), 32'd0);
    end
    @(negedge pix_clk);
    release_reset();

    // Sync delay with random syncs
    for (int i = 0; i < 16; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, '0, '0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, '0, '0);
    step(1, 0, 0, '0, '0);
    step(0, 0, 0, '0, '0);
    step(0, 0, 0, '0, '0);
    chk("vs_lat2", 32'(vs_out), 32'd0);
    step(0, 0, 0, '0, '0);
    chk("vs_lat3", 32'(vs_out), 32'd1);

    // Address table
    foreach (av[i]) begin
      set_frame(av[i].base, 12'hABC, av[i].zoom);
      step(0, 0, 1, av[i].x, 12'd40);
      step(0, 0, 0, '0, '0);
      chk("addr_tbl", 32'(ram_addr), 32'(av[i].exp_addr));
      step(0, 0, 0, '0, '0);
      step(0, 0, 0, '0, '0);
    end

    // Alternating data, zoom 2
    for (int a = 0; a < 4096; a++) mem[a] = (a % 2 == 0) ? 8'h01 : 8'h00;
    set_frame(12'h000, 12'hFFF, 3'd2);
    line(12'd32, 200);  chk("hi_green", 32'(green_cnt), 32'd125);
    line(12'd66, 200);  chk("mid_trans", 32'(green_cnt), 32'd49);
    line(12'd128, 200);
    line(12'd143, 200); chk("row127_none", 32'(green_cnt), 32'd0);
    line(12'd0, 200);   chk("grid_top", 32'(gray_cnt), 32'd4);
    line(12'd160, 200);
    line(12'd1040, 200);

    // Trigger marker, zoom 1
    set_frame(12'h020, 12'h02A, 3'd1);
    line(12'd0, 130);    chk("trig_top", 32'(red_cnt), 32'd1);
    chk("grid_trig", 32'(gray_cnt), 32'd3);
    line(12'd500, 130);  chk("trig_mid", 32'(red_cnt), 32'd1);
    line(12'd1040, 130); chk("trig_bot", 32'(red_cnt), 32'd1);

    // Address wrap with random data
    for (int a = 0; a < 4096; a++) mem[a] = 8'($urandom);
    set_frame(12'hFFE, 12'h800, 3'd0);
    step(0, 0, 1, 12'd0, 12'd32);
    for (int i = 1; i < 5; i++) begin
      step(0, 0, i < 4, (i < 4) ? 12'(i) : 12'd0, 12'd32);
      chk("wrap_seq", 32'(ram_addr), 32'(wrap_seq[i-1]));
    end
    for (int i = 0; i < 4; i++) step(0, 0, 0, '0, '0);
    line(12'd32, 16); line(12'd128, 16); line(12'd300, 16); line(12'd928, 16);

    // Mid-frame base change is ignored until vs; vs with de
    set_frame(12'h040, 12'hFFF, 3'd0);
    step(0, 0, 1, 12'd5, 12'd32);
    step(0, 0, 0, '0, '0);
    chk("base_pre", 32'(ram_addr), 32'h045);
    base_addr = 12'h300;
    step(0, 0, 1, 12'd5, 12'd32);
    step(0, 0, 0, '0, '0);
    chk("base_hold", 32'(ram_addr), 32'h045);
    step(1, 0, 1, 12'd6, 12'd32);
    step(0, 0, 1, 12'd7, 12'd32);
    chk("vs_de_old", 32'(ram_addr), 32'h046);
    step(0, 0, 0, '0, '0);
    chk("vs_de_new", 32'(ram_addr), 32'h307);
    for (int i = 0; i < 4; i++) step(0, 0, 0, '0, '0);

    // Asynchronous reset mid-line
    for (int a = 0; a < 4096; a++) mem[a] = 8'hFF;
    for (int x = 0; x < 10; x++) step(0, 0, 1, 12'(x), 12'd32);
    chk("pre_rst_green", 32'({r_out, g_out, b_out}), 32'h00FF00);
    #3 rstn = 1'b0;
    #1;
    chk("rst_async_rgb", 32'({r_out, g_out, b_out}), 32'd0);
    chk("rst_async_ctl", 32'({de_out, ram_rd_en}), 32'd0);
    release_reset();
    line(12'd32, 20);
    chk("post_rst_trig", 32'(red_cnt), 32'd1);
    step(0, 0, 1, 12'd5, 12'd32);
    step(0, 0, 0, '0, '0);
    chk("post_rst_addr", 32'(ram_addr), 32'h005);
    for (int i = 0; i < 4; i++) step(0, 0, 0, '0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
